// File: rtl/lpor_rca_pkg.sv
// lpor_rca_pkg: shared definitions for the lower-part-OR ripple-carry adder
// (LOA) family and its response monitor.
//   - mon_state_e : monitor FSM states (IDLE, RUN, DRAIN, DONE)
//   - RES_W / HD_W / SEL_W : result, Hamming-distance and bit-select widths
//     for the default 16-bit, 8-bit-lower-part configuration
//   - PIPE_LAT : transfer-to-statistics latency of the monitor
//   - lpor_golden(a, b) : reference approximate sum for the default config
package lpor_rca_pkg;

  localparam int LPOR_WIDTH   = 16;
  localparam int LPOR_LOWER_W = 8;
  localparam int RES_W        = LPOR_WIDTH + 1;
  localparam int HD_W         = $clog2(LPOR_WIDTH + 2);
  localparam int SEL_W        = $clog2(LPOR_WIDTH + 1);
  localparam int PIPE_LAT     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  // Lower part is a plain OR; the upper part is a true add whose carry-in is
  // the AND of the two most significant lower-part bits.
  function automatic logic [RES_W-1:0] lpor_golden(input logic [LPOR_WIDTH-1:0] a,
                                                   input logic [LPOR_WIDTH-1:0] b);
    logic [LPOR_WIDTH-LPOR_LOWER_W:0] hi;
    hi = {1'b0, a[LPOR_WIDTH-1:LPOR_LOWER_W]}
       + {1'b0, b[LPOR_WIDTH-1:LPOR_LOWER_W]}
       + {{(LPOR_WIDTH-LPOR_LOWER_W){1'b0}}, (a[LPOR_LOWER_W-1] & b[LPOR_LOWER_W-1])};
    return {hi, (a[LPOR_LOWER_W-1:0] | b[LPOR_LOWER_W-1:0])};
  endfunction

endpackage

// File: rtl/lpor_rca_hd_monitor_popcount.sv
// lpor_popcount: N-input population count with a registered result.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset (clears the count)
//   vec_i   : N-bit input vector
//   count_o : number of set bits in vec_i, one cycle later
module lpor_popcount
  import lpor_rca_pkg::*;
#(
  parameter int N = 17
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               vec_i,
  output logic [$clog2(N+1)-1:0]     count_o
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] w_count;

  // Adder chain over all input bits.
  always_comb begin
    w_count = CW'(0);
    for (int i = 0; i < N; i++) begin
      w_count = w_count + CW'(vec_i[i]);
    end
  end

  // Result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= CW'(0);
    end else begin
      count_o <= w_count;
    end
  end

endmodule

// File: rtl/lpor_rca_hd_monitor.sv
// lpor_rca_hd_monitor: streaming response checker for the key-locked LOA.
// Recomputes the golden approximate sum of every accepted operand pair, XORs
// it with the locked adder's result and accumulates corruption statistics
// over a window of NUM_VEC vectors.
//   clk_i / rst_i          : clock, asynchronous active-high reset
//   start_i                : pulse; clears statistics and opens a window
//   vec_valid_i / _ready_o : operand/result handshake
//   add1_i, add2_i         : operands applied to the locked adder
//   dut_result_i           : locked adder result for those operands
//   busy_o / done_o        : window open or draining / window complete
//   vec_count_o, mismatch_count_o, hd_sum_o, hd_max_o : window statistics
//   bit_sel_i / bit_err_o  : per-result-bit error count readback
module lpor_rca_hd_monitor
  import lpor_rca_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LOWER_W = 8,
  parameter int NUM_VEC = 5000,
  parameter int CNT_W   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         vec_valid_i,
  output logic                         vec_ready_o,
  input  logic [WIDTH-1:0]             add1_i,
  input  logic [WIDTH-1:0]             add2_i,
  input  logic [WIDTH:0]               dut_result_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             vec_count_o,
  output logic [CNT_W-1:0]             mismatch_count_o,
  output logic [CNT_W-1:0]             hd_sum_o,
  output logic [$clog2(WIDTH+2)-1:0]   hd_max_o,
  input  logic [$clog2(WIDTH+1)-1:0]   bit_sel_i,
  output logic [CNT_W-1:0]             bit_err_o
);

  localparam int L_RES_W = WIDTH + 1;
  localparam int L_HD_W  = $clog2(WIDTH + 2);
  localparam int L_SEL_W = $clog2(WIDTH + 1);
  localparam int ACC_W   = $clog2(NUM_VEC + 1);
  localparam int UP_W    = WIDTH - LOWER_W + 1;
  localparam int SUM_W   = ((CNT_W > L_HD_W) ? CNT_W : L_HD_W) + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0]   ACC_NUM  = ACC_W'(NUM_VEC);
  localparam logic [ACC_W-1:0]   ACC_LAST = ACC_W'(NUM_VEC - 1);
  localparam logic [L_SEL_W-1:0] SEL_MAX  = L_SEL_W'(WIDTH);

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : (c + CNT_W'(1));
  endfunction

  mon_state_e             r_state;
  logic [ACC_W-1:0]       r_accepted;
  logic                   w_start;
  logic                   w_xfer;
  logic [UP_W-1:0]        w_upper;
  logic [L_RES_W-1:0]     w_golden;
  logic                   r_v1;
  logic [L_RES_W-1:0]     r_golden1;
  logic [L_RES_W-1:0]     r_dut1;
  logic [L_RES_W-1:0]     w_diff;
  logic                   r_v2;
  logic [L_RES_W-1:0]     r_diff2;
  logic [L_HD_W-1:0]      w_pop;
  logic [CNT_W-1:0]       r_vec_count;
  logic [CNT_W-1:0]       r_mismatch;
  logic [CNT_W-1:0]       r_hd_sum;
  logic [L_HD_W-1:0]      r_hd_max;
  logic [CNT_W-1:0]       r_bit_err [L_RES_W];
  logic [SUM_W-1:0]       w_sum_wide;
  logic [CNT_W-1:0]       w_sum_sat;

  // start_i only opens a window from IDLE or DONE; ready never looks at valid.
  assign w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign vec_ready_o = (r_state == ST_RUN) && (r_accepted < ACC_NUM);
  assign w_xfer      = vec_valid_i && vec_ready_o;

  // Golden LOA sum (same rule as lpor_golden, at this instance's widths).
  always_comb begin
    w_upper  = {1'b0, add1_i[WIDTH-1:LOWER_W]} + {1'b0, add2_i[WIDTH-1:LOWER_W]}
             + UP_W'(add1_i[LOWER_W-1] & add2_i[LOWER_W-1]);
    w_golden = {w_upper, (add1_i[LOWER_W-1:0] | add2_i[LOWER_W-1:0])};
  end

  // Window FSM and accepted-transfer counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_accepted <= ACC_W'(0);
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state    <= ST_RUN;
            r_accepted <= ACC_W'(0);
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_accepted <= r_accepted + ACC_W'(1);
            if (r_accepted == ACC_LAST) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Both stage valids low means the last vector has been accumulated.
          if (!r_v1 && !r_v2) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stages S1 (golden + result capture) and S2 (difference capture).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1      <= 1'b0;
      r_golden1 <= {L_RES_W{1'b0}};
      r_dut1    <= {L_RES_W{1'b0}};
      r_v2      <= 1'b0;
      r_diff2   <= {L_RES_W{1'b0}};
    end else begin
      r_v1      <= w_xfer;
      r_golden1 <= w_golden;
      r_dut1    <= dut_result_i;
      r_v2      <= r_v1;
      r_diff2   <= w_diff;
    end
  end

  assign w_diff = r_golden1 ^ r_dut1;

  // Registered Hamming distance, aligned with r_diff2 / r_v2.
  lpor_popcount #(.N(L_RES_W)) u_popcount (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .vec_i   (w_diff),
    .count_o (w_pop)
  );

  // Saturating Hamming-distance accumulation.
  always_comb begin
    w_sum_wide = SUM_W'(r_hd_sum) + SUM_W'(w_pop);
    if (w_sum_wide > SUM_W'(CNT_MAX)) begin
      w_sum_sat = CNT_MAX;
    end else begin
      w_sum_sat = w_sum_wide[CNT_W-1:0];
    end
  end

  // Stage S3: statistics update; cleared when a window opens.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vec_count <= CNT_W'(0);
      r_mismatch  <= CNT_W'(0);
      r_hd_sum    <= CNT_W'(0);
      r_hd_max    <= L_HD_W'(0);
      for (int i = 0; i < L_RES_W; i++) begin
        r_bit_err[i] <= CNT_W'(0);
      end
    end else if (w_start) begin
      r_vec_count <= CNT_W'(0);
      r_mismatch  <= CNT_W'(0);
      r_hd_sum    <= CNT_W'(0);
      r_hd_max    <= L_HD_W'(0);
      for (int i = 0; i < L_RES_W; i++) begin
        r_bit_err[i] <= CNT_W'(0);
      end
    end else if (r_v2) begin
      r_vec_count <= sat_inc(r_vec_count);
      if (w_pop != L_HD_W'(0)) begin
        r_mismatch <= sat_inc(r_mismatch);
      end
      r_hd_sum <= w_sum_sat;
      if (w_pop > r_hd_max) begin
        r_hd_max <= w_pop;
      end
      for (int i = 0; i < L_RES_W; i++) begin
        if (r_diff2[i]) begin
          r_bit_err[i] <= sat_inc(r_bit_err[i]);
        end
      end
    end
  end

  // Per-bit readback; out-of-range selects read as zero.
  always_comb begin
    bit_err_o = CNT_W'(0);
    if (bit_sel_i <= SEL_MAX) begin
      bit_err_o = r_bit_err[bit_sel_i];
    end else begin
      bit_err_o = CNT_W'(0);
    end
  end

  assign busy_o           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done_o           = (r_state == ST_DONE);
  assign vec_count_o      = r_vec_count;
  assign mismatch_count_o = r_mismatch;
  assign hd_sum_o         = r_hd_sum;
  assign hd_max_o         = r_hd_max;

endmodule

// File: tb/tb_lpor_rca_hd_monitor.sv
// Scoreboard bench for lpor_rca_hd_monitor. Three instances:
//   0: defaults (NUM_VEC=5000), 1: NUM_VEC=8, 2: NUM_VEC=20 with CNT_W=4.
// The driver pushes the expected window statistics when it opens a window;
// one monitor per instance pops and compares when done_o rises.
module tb_lpor_rca_hd_monitor;
  import lpor_rca_pkg::*;

  typedef struct packed {
    logic [15:0]       vc;
    logic [15:0]       mc;
    logic [15:0]       hs;
    logic [4:0]        hm;
    logic [16:0][15:0] be;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start [3];
  logic        vv    [3];
  logic [15:0] a1    [3];
  logic [15:0] a2    [3];
  logic [16:0] dr    [3];
  logic [4:0]  sel   [3];
  wire         rdy   [3];
  wire         busy  [3];
  wire         done  [3];
  wire  [15:0] vc    [3];
  wire  [15:0] mc    [3];
  wire  [15:0] hs    [3];
  wire  [15:0] be    [3];
  wire  [4:0]  hm    [3];
  wire  [3:0]  vc2, mc2, hs2, be2;

  exp_t sbq [3][$];
  int n_checks = 0;
  int n_errs   = 0;

  lpor_rca_hd_monitor #(.NUM_VEC(5000)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .vec_valid_i(vv[0]), .vec_ready_o(rdy[0]),
    .add1_i(a1[0]), .add2_i(a2[0]), .dut_result_i(dr[0]), .busy_o(busy[0]), .done_o(done[0]),
    .vec_count_o(vc[0]), .mismatch_count_o(mc[0]), .hd_sum_o(hs[0]), .hd_max_o(hm[0]),
    .bit_sel_i(sel[0]), .bit_err_o(be[0]));

  lpor_rca_hd_monitor #(.NUM_VEC(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .vec_valid_i(vv[1]), .vec_ready_o(rdy[1]),
    .add1_i(a1[1]), .add2_i(a2[1]), .dut_result_i(dr[1]), .busy_o(busy[1]), .done_o(done[1]),
    .vec_count_o(vc[1]), .mismatch_count_o(mc[1]), .hd_sum_o(hs[1]), .hd_max_o(hm[1]),
    .bit_sel_i(sel[1]), .bit_err_o(be[1]));

  lpor_rca_hd_monitor #(.NUM_VEC(20), .CNT_W(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .vec_valid_i(vv[2]), .vec_ready_o(rdy[2]),
    .add1_i(a1[2]), .add2_i(a2[2]), .dut_result_i(dr[2]), .busy_o(busy[2]), .done_o(done[2]),
    .vec_count_o(vc2), .mismatch_count_o(mc2), .hd_sum_o(hs2), .hd_max_o(hm[2]),
    .bit_sel_i(sel[2]), .bit_err_o(be2));

  assign vc[2] = {12'd0, vc2};
  assign mc[2] = {12'd0, mc2};
  assign hs[2] = {12'd0, hs2};
  assign be[2] = {12'd0, be2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Called just after a falling edge; leaves start high across one rising edge.
  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Present one triple and hold it until accepted; returns after the transfer edge.
  task automatic xfer(input int k, input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
    int t;
    t = 0;
    a1[k] = a; a2[k] = b; dr[k] = r; vv[k] = 1'b1;
    while (!rdy[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[k]) begin
      n_checks++; n_errs++;
      $display("FAIL xfer_timeout inst%0d", k);
      vv[k] = 1'b0;
    end else begin
      @(negedge clk);
      vv[k] = 1'b0;
    end
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (!done[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!done[k]) begin
      n_checks++; n_errs++;
      $display("FAIL done_timeout inst%0d", k);
    end
  endtask

  task automatic wait_sb(input int k);
    int t;
    t = 0;
    while (sbq[k].size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sbq[k].size() != 0) begin
      n_checks++; n_errs++;
      $display("FAIL scoreboard_pending inst%0d entries %0d", k, sbq[k].size());
      sbq[k].delete();
    end
  endtask

  // Monitors: compare a finished window against the oldest expectation.
  for (genvar k = 0; k < 3; k++) begin : g_mon
    initial begin
      exp_t e;
      sel[k] = 5'd0;
      forever begin
        @(posedge done[k]);
        @(negedge clk);
        if (sbq[k].size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_done inst%0d", k);
        end else begin
          e = sbq[k][0];
          chk($sformatf("vec_count%0d", k), 32'(vc[k]), 32'(e.vc));
          chk($sformatf("mismatch%0d", k),  32'(mc[k]), 32'(e.mc));
          chk($sformatf("hd_sum%0d", k),    32'(hs[k]), 32'(e.hs));
          chk($sformatf("hd_max%0d", k),    32'(hm[k]), 32'(e.hm));
          chk($sformatf("busy_at_done%0d", k), 32'(busy[k]), 32'd0);
          for (int b = 0; b < 17; b++) begin
            sel[k] = 5'(b);
            #1;
            chk($sformatf("bit_err%0d[%0d]", k, b), 32'(be[k]), 32'(e.be[b]));
          end
          sel[k] = 5'd17;
          #1;
          chk($sformatf("bit_err%0d_sel17", k), 32'(be[k]), 32'd0);
          sel[k] = 5'd31;
          #1;
          chk($sformatf("bit_err%0d_sel31", k), 32'(be[k]), 32'd0);
          sel[k] = 5'd0;
          void'(sbq[k].pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [15:0] a, b;
    int lat, idx, cyc;
    logic took, mid;

    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; vv[i] = 1'b0; a1[i] = 16'd0; a2[i] = 16'd0; dr[i] = 17'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_vc%0d", k),   32'(vc[k]),   32'd0);
      chk($sformatf("rst_mc%0d", k),   32'(mc[k]),   32'd0);
      chk($sformatf("rst_hs%0d", k),   32'(hs[k]),   32'd0);
      chk($sformatf("rst_hm%0d", k),   32'(hm[k]),   32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst_rdy%0d", k),  32'(rdy[k]),  32'd0);
    end

    // Window A: 5000 matched vectors
    e = '0; e.vc = 16'd5000;
    sbq[0].push_back(e);
    pulse_start(0);
    for (int i = 0; i < 5000; i++) begin
      a = 16'(i * 40503);
      b = 16'(i * 7919 + 3);
      xfer(0, a, b, lpor_golden(a, b));
    end
    lat = 0;
    while (!done[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 32'(lat), 32'd3);
    wait_sb(0);

    // Window B: flipped bit, carry-in rule, carry-out boundary, zeros
    e = '0; e.vc = 16'd5000; e.mc = 16'd2; e.hs = 16'd2; e.hm = 5'd1;
    e.be[8] = 16'd1; e.be[7] = 16'd1;
    sbq[0].push_back(e);
    pulse_start(0);
    for (int i = 0; i < 5000; i++) begin
      case (i)
        0: xfer(0, 16'h00FF, 16'h0101, 17'h000FF);
        1: xfer(0, 16'h0080, 16'h0080, 17'h00100);
        2: xfer(0, 16'hFFFF, 16'hFFFF, 17'h1FFFF);
        3: xfer(0, 16'hFF00, 16'h0100, 17'h10000);
        default: xfer(0, 16'h0000, 16'h0000, 17'h00000);
      endcase
      if (i >= 1 && i <= 3) begin
        chk($sformatf("pipe_vc_after_%0d", i), 32'(vc[0]), 32'(i - 1));
      end
      if (i >= 2 && i <= 3) begin
        chk($sformatf("pipe_mc_after_%0d", i), 32'(mc[0]), 32'(i - 1));
      end
    end
    wait_done(0);
    wait_sb(0);

    // Window C: backpressure with random valid, ignored mid-window start
    e = '0; e.vc = 16'd8; e.mc = 16'd8; e.hs = 16'd8; e.hm = 5'd1;
    for (int j = 0; j < 8; j++) e.be[j] = 16'd1;
    sbq[1].push_back(e);
    pulse_start(1);
    idx = 0; cyc = 0; mid = 1'b0;
    while (idx < 8 && cyc < 400) begin
      start[1] = 1'b0;
      if (idx == 4 && !mid) begin
        start[1] = 1'b1;
        mid = 1'b1;
      end
      a = 16'h1357 + 16'(idx * 515);
      b = 16'h2468 ^ 16'(idx * 4099);
      a1[1] = a; a2[1] = b;
      dr[1] = lpor_golden(a, b) ^ (17'd1 << idx);
      vv[1] = 1'($urandom_range(0, 1));
      took = vv[1] && rdy[1];
      @(negedge clk);
      cyc++;
      if (took) idx++;
    end
    start[1] = 1'b0;
    chk("bp_transfers", 32'(idx), 32'd8);
    chk("bp_ready_after_last", 32'(rdy[1]), 32'd0);
    chk("bp_busy_after_last", 32'(busy[1]), 32'd1);
    for (int i = 0; i < 20; i++) begin
      vv[1] = 1'($urandom_range(0, 1));
      dr[1] = 17'h1FFFF;
      @(negedge clk);
    end
    vv[1] = 1'b0;
    wait_done(1);
    wait_sb(1);

    // Window D: saturation with CNT_W=4, every result fully inverted
    e = '0; e.vc = 16'd15; e.mc = 16'd15; e.hs = 16'd15; e.hm = 5'd17;
    for (int j = 0; j < 17; j++) e.be[j] = 16'd15;
    sbq[2].push_back(e);
    pulse_start(2);
    for (int i = 0; i < 20; i++) begin
      a = 16'(i * 4369);
      b = 16'(16'hF0F0 - 16'(i * 257));
      xfer(2, a, b, ~lpor_golden(a, b));
    end
    wait_done(2);
    wait_sb(2);

    // Async reset in the middle of a window
    pulse_start(1);
    for (int i = 0; i < 3; i++) begin
      xfer(1, 16'(16'h0F0F + i), 16'h3030, lpor_golden(16'(16'h0F0F + i), 16'h3030) ^ 17'h00003);
    end
    repeat (3) @(negedge clk);
    chk("mid_vc", 32'(vc[1]), 32'd3);
    chk("mid_hs", 32'(hs[1]), 32'd6);
    chk("mid_busy", 32'(busy[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vc", 32'(vc[1]), 32'd0);
    chk("arst_mc", 32'(mc[1]), 32'd0);
    chk("arst_hs", 32'(hs[1]), 32'd0);
    chk("arst_hm", 32'(hm[1]), 32'd0);
    chk("arst_busy", 32'(busy[1]), 32'd0);
    chk("arst_rdy", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);
    chk("post_rst_done", 32'(done[1]), 32'd0);
    chk("post_rst_rdy", 32'(rdy[1]), 32'd0);
    e = '0; e.vc = 16'd8;
    sbq[1].push_back(e);
    pulse_start(1);
    for (int i = 0; i < 8; i++) begin
      a = 16'(i * 9001);
      b = 16'(16'hA5A5 + i);
      xfer(1, a, b, lpor_golden(a, b));
    end
    wait_done(1);
    wait_sb(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/lpor_rca_hd_monitor.md
Name: lpor_rca_hd_monitor

Overview:
- Streaming response checker for the 16-bit key-locked lower-part-OR ripple-carry adder. The stimulus side produces operand pairs; this block sits on the result end of that flow.
- For each accepted vector it recomputes the golden approximate sum and XORs it with the locked netlist's result_o. It accumulates vector count, mismatching-vector count, total and maximum Hamming distance, and per-output-bit error counts over a fixed window.
- Used in hardware/emulation key-sweep campaigns so wrong-key corruption metrics are produced without $monitor log post-processing.

Parameters:
- WIDTH, 16, operand width; result width is WIDTH+1.
- LOWER_W, 8, width of the OR-approximated lower part (1 to WIDTH-1).
- NUM_VEC, 5000, vectors per measurement window.
- CNT_W, 16, width of every count/accumulator (saturating).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- start_i  input  1  single-cycle pulse; clears statistics and opens a window.
- vec_valid_i  input  1  operand/result triple is valid.
- vec_ready_o  output  1  block accepts the triple this cycle.
- add1_i  input  WIDTH  operand 1 as applied to the locked adder.
- add2_i  input  WIDTH  operand 2 as applied to the locked adder.
- dut_result_i  input  WIDTH+1  locked adder result_o for that operand pair.
- busy_o  output  1  window open or pipeline draining.
- done_o  output  1  window complete; statistics stable.
- vec_count_o  output  CNT_W  vectors accepted in the window.
- mismatch_count_o  output  CNT_W  vectors with Hamming distance greater than 0.
- hd_sum_o  output  CNT_W  sum of per-vector Hamming distances.
- hd_max_o  output  $clog2(WIDTH+2)  largest per-vector Hamming distance.
- bit_sel_i  input  $clog2(WIDTH+1)  per-bit counter readback select.
- bit_err_o  output  CNT_W  error count of result bit bit_sel_i (combinational mux). Returns 0 when bit_sel_i > WIDTH.

Behaviour:
- Reset: state IDLE. All counters 0. vec_ready_o, busy_o and done_o are 0. Pipeline valid bits cleared. Reset asserted mid-window discards the window; nothing resumes after release.
- Golden model:
  - g[LOWER_W-1:0] = add1_i | add2_i on the lower bits.
  - g[WIDTH:LOWER_W] = add1_i[WIDTH-1:LOWER_W] + add2_i[WIDTH-1:LOWER_W] + (add1_i[LOWER_W-1] & add2_i[LOWER_W-1]), computed at full width including carry-out.
- Handshake: a transfer occurs when vec_valid_i and vec_ready_o are both 1. vec_ready_o = (state==RUN) and (accepted < NUM_VEC). It has no combinational dependency on vec_valid_i.
- Pipeline:
  - S1: register the inputs and the golden result.
  - S2: diff = g ^ dut; register diff and popcount(diff).
  - S3: update the accumulators.
  - Statistics reflect a transfer 3 cycles after it (fixed latency). Back-to-back transfers sustain one vector per cycle.
- Accumulation per S3 valid:
  - vec_count +1.
  - mismatch +1 if popcount > 0.
  - hd_sum += popcount.
  - hd_max = max(hd_max, popcount).
  - bit_err[i] +1 for each set diff[i].
  - All counters saturate at 2^CNT_W-1 and never wrap.
- FSM:
  - IDLE --start_i--> RUN (counters cleared on the same edge).
  - RUN --NUM_VEC-th transfer--> DRAIN.
  - DRAIN --pipeline empty (3 cycles)--> DONE.
  - DONE --start_i--> RUN (clears).
- start_i during RUN or DRAIN is ignored.
- busy_o = RUN or DRAIN. done_o = DONE, held until the next start_i.
- Transfer and state change on the same edge: the NUM_VEC-th transfer is counted; vec_ready_o is 0 from the next cycle.
- The accepted counter is internal and distinct from vec_count_o. Its width is $clog2(NUM_VEC+1).

Decomposition:
- Shared package lpor_rca_pkg:
  - monitor state enum (IDLE, RUN, DRAIN, DONE).
  - localparams RES_W=WIDTH+1, HD_W, SEL_W.
  - pipeline latency constant (3).
  - golden-LOA function lpor_golden(a, b), shared with the adder's behavioural model and the testbench.
- One sub-module: lpor_popcount (parameterised WIDTH+1-input population count, registered output), instantiated in S2.

Test Plan:
- Matched result: start_i, 5000 vectors with dut_result_i = golden -> done_o=1 after last transfer +3 cycles; vec_count_o=5000, mismatch_count_o=0, hd_sum_o=0, hd_max_o=0.
- Single flipped bit: WIDTH=16, LOWER_W=8, add1=16'h00FF, add2=16'h0101 -> golden 17'h001FF. Drive dut_result_i=17'h000FF -> mismatch=1, hd_sum=1, bit_sel_i=8 gives bit_err_o=1, all other bits 0.
- Carry-in rule: add1=16'h0080, add2=16'h0080 -> golden 17'h00180. Driving exact sum 17'h00100 gives HD=1 on bit 7.
- Backpressure and gaps: vec_valid_i toggling randomly with NUM_VEC=8 -> exactly 8 transfers counted; vec_ready_o=0 from the cycle after the 8th; start_i during RUN has no effect.
- Saturation: CNT_W=4, 20 vectors each with HD=17 (dut = ~golden) -> hd_sum_o=15, mismatch_count_o=15, hd_max_o=17.
- Async reset: assert rst_i mid-window between clock edges -> outputs 0 immediately; after release state is IDLE; a new start_i runs a clean window.
